// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port data memory between instruction fetch and load/store.
// Data has priority; a bounded data streak guarantees fetch forward progress.
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int LAT        = 2,
   parameter int MAX_STREAK = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ready,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_wen,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ready,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;
   localparam int STK_W = $clog2(MAX_STREAK + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t              state_r, state_s;
   logic [CNT_W-1:0]    cnt_r, cnt_s;
   logic [STK_W-1:0]    streak_r, streak_s;
   logic                grant_fetch_r, grant_fetch_s;
   logic [ADDR_W-1:0]   addr_r, addr_s;
   logic                wen_r, wen_s;
   logic [DATA_W-1:0]   wdata_r, wdata_s;
   logic [DATA_W-1:0]   if_rdata_r, if_rdata_s;
   logic [DATA_W-1:0]   d_rdata_r, d_rdata_s;
   logic                fetch_win_s;
   logic                streak_full_s;

   assign streak_full_s = (streak_r == STK_W'(MAX_STREAK));
   assign fetch_win_s   = if_req && (!d_req || streak_full_s);

   // Next-state logic: grant in IDLE, count the access latency, then respond.
   always_comb begin
      state_s       = state_r;
      cnt_s         = cnt_r;
      streak_s      = streak_r;
      grant_fetch_s = grant_fetch_r;
      addr_s        = addr_r;
      wen_s         = wen_r;
      wdata_s       = wdata_r;
      if_rdata_s    = if_rdata_r;
      d_rdata_s     = d_rdata_r;
      case (state_r)
         IDLE: begin
            if (if_req || d_req) begin
               state_s = ACCESS;
               cnt_s   = {CNT_W{1'b0}};
               if (fetch_win_s) begin
                  grant_fetch_s = 1'b1;
                  addr_s        = if_addr;
                  wen_s         = 1'b0;
                  wdata_s       = {DATA_W{1'b0}};
                  streak_s      = {STK_W{1'b0}};
               end else begin
                  grant_fetch_s = 1'b0;
                  addr_s        = d_addr;
                  wen_s         = d_wen;
                  wdata_s       = d_wdata;
                  // Streak only grows while fetch is actually waiting.
                  if (!if_req) begin
                     streak_s = {STK_W{1'b0}};
                  end else if (streak_full_s) begin
                     streak_s = streak_r;
                  end else begin
                     streak_s = streak_r + STK_W'(1);
                  end
               end
            end else begin
               state_s = IDLE;
            end
         end
         ACCESS: begin
            if (cnt_r == CNT_W'(LAT - 1)) begin
               state_s = RESP;
               cnt_s   = {CNT_W{1'b0}};
               if (grant_fetch_r) begin
                  if_rdata_s = mem_rdata;
               end else if (!wen_r) begin
                  d_rdata_s = mem_rdata;
               end else begin
                  d_rdata_s = d_rdata_r;
               end
            end else begin
               cnt_s = cnt_r + CNT_W'(1);
            end
         end
         RESP: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State and latched-request registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= IDLE;
         cnt_r         <= {CNT_W{1'b0}};
         streak_r      <= {STK_W{1'b0}};
         grant_fetch_r <= 1'b0;
         addr_r        <= {ADDR_W{1'b0}};
         wen_r         <= 1'b0;
         wdata_r       <= {DATA_W{1'b0}};
         if_rdata_r    <= {DATA_W{1'b0}};
         d_rdata_r     <= {DATA_W{1'b0}};
      end else begin
         state_r       <= state_s;
         cnt_r         <= cnt_s;
         streak_r      <= streak_s;
         grant_fetch_r <= grant_fetch_s;
         addr_r        <= addr_s;
         wen_r         <= wen_s;
         wdata_r       <= wdata_s;
         if_rdata_r    <= if_rdata_s;
         d_rdata_r     <= d_rdata_s;
      end
   end

   assign mem_en    = (state_r == ACCESS);
   assign mem_wen   = (state_r == ACCESS) && wen_r;
   assign mem_addr  = addr_r;
   assign mem_wdata = wdata_r;
   assign if_ready  = (state_r == RESP) && grant_fetch_r;
   assign d_ready   = (state_r == RESP) && !grant_fetch_r;
   assign busy      = (state_r != IDLE);
   assign if_rdata  = if_rdata_r;
   assign d_rdata   = d_rdata_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic checked
// against a transaction-timing model; a second instance covers LAT = 1.
module tb_mem_port_arbiter;

   localparam int LAT = 2;
   localparam int MAX = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic        if_req = 1'b0, d_req = 1'b0, d_wen = 1'b0;
   logic [31:0] if_addr = 32'd0, d_addr = 32'd0, d_wdata = 32'd0;
   logic        if_ready, d_ready, mem_en, mem_wen, busy;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [31:0] en_run = 32'd0;

   logic        if_req1 = 1'b0, d_req1 = 1'b0, d_wen1 = 1'b0;
   logic [31:0] if_addr1 = 32'd0, d_addr1 = 32'd0, d_wdata1 = 32'd0;
   logic        if_ready1, d_ready1, mem_en1, mem_wen1, busy1;
   logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
   logic [31:0] en_run1 = 32'd0;

   function automatic logic [31:0] rom(input logic [31:0] a);
      if (a == 32'h40) return 32'hDEADBEEF;
      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   // Memory presents valid data only in the LAT-th enabled cycle; junk otherwise.
   assign mem_rdata  = (mem_en  === 1'b1 && en_run  == 32'(LAT - 1)) ? rom(mem_addr)  : 32'hBAD0BAD0;
   assign mem_rdata1 = (mem_en1 === 1'b1 && en_run1 == 32'd0)        ? rom(mem_addr1) : 32'hBAD0BAD0;
   always @(posedge clk) begin
      en_run  <= (mem_en  === 1'b1) ? en_run  + 32'd1 : 32'd0;
      en_run1 <= (mem_en1 === 1'b1) ? en_run1 + 32'd1 : 32'd0;
   end

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(LAT), .MAX_STREAK(MAX)) u0 (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
      .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ready(d_ready), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy));

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(1), .MAX_STREAK(MAX)) u1 (
      .clk(clk), .rst(rst),
      .if_req(if_req1), .if_addr(if_addr1), .if_ready(if_ready1), .if_rdata(if_rdata1),
      .d_req(d_req1), .d_wen(d_wen1), .d_addr(d_addr1), .d_wdata(d_wdata1),
      .d_ready(d_ready1), .d_rdata(d_rdata1),
      .mem_en(mem_en1), .mem_wen(mem_wen1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
      .mem_rdata(mem_rdata1), .busy(busy1));

   int n_err = 0;
   int n_chk = 0;

   // Reference model: cycles since grant (0 = idle), grantee and latched request.
   int          ph = 0;
   bit          g_fetch = 1'b0;
   bit          l_wen = 1'b0;
   logic [31:0] l_addr = 32'd0, l_wdata = 32'd0;
   int          streak = 0;
   logic [31:0] e_if = 32'd0, e_d = 32'd0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_chk++;
      assert (obs === want) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, want, $time);
      end
   endtask

   // Predicts the effect of the upcoming rising edge from the inputs now driven.
   task automatic edge_update();
      if (rst) begin
         ph = 0; streak = 0; e_if = 32'd0; e_d = 32'd0;
         g_fetch = 1'b0; l_wen = 1'b0; l_addr = 32'd0; l_wdata = 32'd0;
      end else if (ph == 0) begin
         if (if_req && (!d_req || streak == MAX)) begin
            g_fetch = 1'b1; l_addr = if_addr; l_wen = 1'b0; streak = 0; ph = 1;
         end else if (d_req) begin
            g_fetch = 1'b0; l_addr = d_addr; l_wen = d_wen; l_wdata = d_wdata; ph = 1;
            streak = if_req ? ((streak < MAX) ? streak + 1 : MAX) : 0;
         end
      end else if (ph <= LAT) begin
         if (ph == LAT) begin
            if (g_fetch) e_if = rom(l_addr);
            else if (!l_wen) e_d = rom(l_addr);
         end
         ph++;
      end else begin
         ph = 0;
      end
   endtask

   task automatic check_cycle();
      bit en_e;
      bit wr_e;
      en_e = (ph >= 1 && ph <= LAT);
      wr_e = en_e && !g_fetch && l_wen;
      chk("mem_en",   32'(mem_en),   32'(en_e));
      chk("busy",     32'(busy),     32'(ph != 0));
      chk("if_ready", 32'(if_ready), 32'(ph == LAT + 1 && g_fetch));
      chk("d_ready",  32'(d_ready),  32'(ph == LAT + 1 && !g_fetch));
      chk("mem_wen",  32'(mem_wen),  32'(wr_e));
      if (en_e) chk("mem_addr", mem_addr, l_addr);
      if (wr_e) chk("mem_wdata", mem_wdata, l_wdata);
      chk("if_rdata", if_rdata, e_if);
      chk("d_rdata",  d_rdata,  e_d);
   endtask

   task automatic tick();
      edge_update();
      @(negedge clk);
      check_cycle();
   endtask

   initial begin
      byte   order_q[$];
      string want_s;

      // Reset values
      rst = 1'b1;
      tick(); tick();
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      rst = 1'b0;
      tick();

      // Single load from 0x40
      d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h40;
      tick(); d_req = 1'b0;
      tick(); tick(); tick();
      chk("load_data", d_rdata, 32'hDEADBEEF);

      // Store: d_rdata must not change
      d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h80; d_wdata = 32'h12345678;
      tick(); d_req = 1'b0;
      tick(); tick(); tick();
      chk("store_keeps_d_rdata", d_rdata, 32'hDEADBEEF);
      d_wen = 1'b0;

      // Back-to-back fetch with the request held across the ready pulse
      if_req = 1'b1; if_addr = 32'h0;
      tick(); tick(); tick();
      if_addr = 32'h4;
      tick(); tick(); tick(); tick();
      if_req = 1'b0;
      chk("fetch_data2", if_rdata, rom(32'h4));
      tick();

      // Contention from zero streak: expect DDDDF then D
      rst = 1'b1; tick(); rst = 1'b0;
      if_addr = 32'h100; d_addr = 32'h200; d_wen = 1'b0;
      for (int c = 0; c < 60 && order_q.size() < 6; c++) begin
         if_req = 1'b1; d_req = 1'b1;
         tick();
         if_req = 1'b1; d_req = 1'b1;
         if (if_ready) begin order_q.push_back(8'h46); if_req = 1'b0; end
         if (d_ready)  begin order_q.push_back(8'h44); d_req  = 1'b0; end
      end
      if_req = 1'b0; d_req = 1'b0;
      want_s = "DDDDFD";
      chk("grant_count", 32'(order_q.size()), 32'd6);
      for (int i = 0; i < order_q.size() && i < 6; i++)
         chk("grant_order", 32'(order_q[i]), 32'(want_s[i]));
      tick(); tick(); tick(); tick();

      // Reset during the second ACCESS cycle
      d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h40;
      tick(); d_req = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      chk("midrst_mem_en", 32'(mem_en), 32'd0);
      chk("midrst_d_rdata", d_rdata, 32'd0);
      rst = 1'b0;
      tick(); tick();

      // Random traffic; grantee addresses are scribbled while in flight
      for (int c = 0; c < 800; c++) begin
         if (ph == LAT + 1 && g_fetch) begin
            if_req = ($urandom_range(0, 3) != 0); if_addr = $urandom_range(0, 255) << 2;
         end else if (ph >= 1 && ph <= LAT && g_fetch) begin
            if_addr = $urandom;
         end else if (!if_req) begin
            if_req = 1'($urandom_range(0, 1)); if_addr = $urandom_range(0, 255) << 2;
         end
         if (ph == LAT + 1 && !g_fetch) begin
            d_req = ($urandom_range(0, 3) != 0); d_addr = $urandom_range(0, 255) << 2;
            d_wen = 1'($urandom_range(0, 1)); d_wdata = $urandom;
         end else if (ph >= 1 && ph <= LAT && !g_fetch) begin
            d_addr = $urandom; d_wdata = $urandom; d_wen = 1'($urandom_range(0, 1));
         end else if (!d_req) begin
            d_req = 1'($urandom_range(0, 1)); d_addr = $urandom_range(0, 255) << 2;
            d_wen = 1'($urandom_range(0, 1)); d_wdata = $urandom;
         end
         tick();
      end
      if_req = 1'b0; d_req = 1'b0;
      for (int c = 0; c < 6; c++) tick();

      // LAT = 1 instance: single load, ready two cycles after sampling
      d_req1 = 1'b1; d_wen1 = 1'b0; d_addr1 = 32'h100;
      tick();
      d_req1 = 1'b0;
      chk("lat1_en_t1", 32'(mem_en1), 32'd1);
      chk("lat1_ready_t1", 32'(d_ready1), 32'd0);
      tick();
      chk("lat1_ready_t2", 32'(d_ready1), 32'd1);
      chk("lat1_en_t2", 32'(mem_en1), 32'd0);
      chk("lat1_data", d_rdata1, rom(32'h100));
      tick();
      chk("lat1_ready_t3", 32'(d_ready1), 32'd0);
      chk("lat1_busy_t3", 32'(busy1), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
